// File: rtl/fluid_board_soc_dpram_mailbox.sv
// fluid_board_soc_dpram_mailbox
// True dual-port shared RAM between the NIOS fluid controller (port 1) and
// the ARM HPS bridge (port 2), both Avalon-MM slaves on one clock.
// Features: byte-lane writes, READ_LATENCY of 1 or 2 with readdatavalid,
// per-port clock enables and a global freeze (reset_req), deterministic
// same-address write collision handling, and a doorbell interrupt in each
// direction.
// Optional: define FLUID_DPRAM_COLLISION_CNT_EN to add the saturating
// collision_count output.
module fluid_board_soc_dpram_mailbox #(
    parameter int    DATA_W       = 16,
    parameter int    ADDR_W       = 14,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "fluid_board_soc_dpram_mailbox.hex",
    parameter int    BE_W         = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reset_req,
    input  logic [ADDR_W-1:0] address,
    input  logic [BE_W-1:0]   byteenable,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    input  logic              clken,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid,
    input  logic [ADDR_W-1:0] address2,
    input  logic [BE_W-1:0]   byteenable2,
    input  logic              chipselect2,
    input  logic              read2,
    input  logic              write2,
    input  logic [DATA_W-1:0] writedata2,
    input  logic              clken2,
    output logic [DATA_W-1:0] readdata2,
    output logic              readdatavalid2,
    output logic              irq,
    output logic              irq2
`ifdef FLUID_DPRAM_COLLISION_CNT_EN
    ,
    output logic [15:0]       collision_count
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Doorbell words at the top of the address space; still ordinary RAM.
    localparam logic [ADDR_W-1:0] DOORBELL_TO_ARM  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] DOORBELL_TO_NIOS = {{(ADDR_W-1){1'b1}}, 1'b0};

    // The synthesis tool picks up the initial contents through this attribute.
    (* ram_init_file = INIT_FILE *)
    logic [DATA_W-1:0] mem [DEPTH];

    // Index 0 = port 1 (NIOS), index 1 = port 2 (ARM).
    logic [1:0][ADDR_W-1:0] addr_a;
    logic [1:0][BE_W-1:0]   be_a;
    logic [1:0][DATA_W-1:0] wdata_a;
    logic [1:0][DATA_W-1:0] rdata_a;
    logic [1:0]             rvld_a;
    logic [1:0]             en_a;
    logic [1:0]             acc_a;
    logic [1:0]             wr_a;
    logic [1:0]             rd_a;

    assign addr_a  = {address2, address};
    assign be_a    = {byteenable2, byteenable};
    assign wdata_a = {writedata2, writedata};

    // reset_req freezes both ports exactly like a dropped clken.
    assign en_a  = {clken2, clken} & {2{~reset_req}};
    assign acc_a = {chipselect2, chipselect} & en_a;
    // A combined read+write is a write only; no read is issued.
    assign wr_a  = acc_a & {write2, write};
    assign rd_a  = acc_a & {read2, read} & ~{write2, write};

    // Byte-lane writes; port 1 is applied last so it owns lanes both ports enable.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BE_W; b++) begin
            if (wr_a[1] && be_a[1][b]) mem[addr_a[1]][b*8 +: 8] <= wdata_a[1][b*8 +: 8];
            if (wr_a[0] && be_a[0][b]) mem[addr_a[0]][b*8 +: 8] <= wdata_a[0][b*8 +: 8];
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        if (READ_LATENCY == 2) begin : g_rl2
            logic [DATA_W-1:0] ram_q_p0;
            logic              vld_p0;
            logic [DATA_W-1:0] rdata_p1;
            logic              vld_p1;

            // ---- stage 0: array read (old data on read-during-write) ----
            // Array output register; only loads on an accepted read.
            always_ff @(posedge clk) begin
                if (rd_a[p]) ram_q_p0 <= mem[addr_a[p]];
            end

            // Stage-0 valid; holds while the port is stalled.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vld_p0 <= 1'b0;
                end else if (en_a[p]) begin
                    vld_p0 <= rd_a[p];
                end
            end

            // ---- stage 1: output register ----
            // Output stage; emits nothing while stalled so pending data is kept.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vld_p1   <= 1'b0;
                    rdata_p1 <= '0;
                end else begin
                    vld_p1 <= en_a[p] & vld_p0;
                    if (en_a[p] && vld_p0) rdata_p1 <= ram_q_p0;
                end
            end

            assign rdata_a[p] = rdata_p1;
            assign rvld_a[p]  = vld_p1;
        end else begin : g_rl1
            logic [DATA_W-1:0] rdata_p0;
            logic              vld_p0;

            // ---- stage 0: array read straight into the output register ----
            // Single-cycle read; data holds when no read is accepted.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vld_p0   <= 1'b0;
                    rdata_p0 <= '0;
                end else begin
                    vld_p0 <= rd_a[p];
                    if (rd_a[p]) rdata_p0 <= mem[addr_a[p]];
                end
            end

            assign rdata_a[p] = rdata_p0;
            assign rvld_a[p]  = vld_p0;
        end
    end

    assign readdata       = rdata_a[0];
    assign readdatavalid  = rvld_a[0];
    assign readdata2      = rdata_a[1];
    assign readdatavalid2 = rvld_a[1];

    // Doorbells: writer rings, reader acknowledges; a ring beats an ack in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq  <= 1'b0;
            irq2 <= 1'b0;
        end else begin
            if (wr_a[0] && addr_a[0] == DOORBELL_TO_ARM) begin
                irq2 <= 1'b1;
            end else if (rd_a[1] && addr_a[1] == DOORBELL_TO_ARM) begin
                irq2 <= 1'b0;
            end
            if (wr_a[1] && addr_a[1] == DOORBELL_TO_NIOS) begin
                irq <= 1'b1;
            end else if (rd_a[0] && addr_a[0] == DOORBELL_TO_NIOS) begin
                irq <= 1'b0;
            end
        end
    end

`ifdef FLUID_DPRAM_COLLISION_CNT_EN
    localparam logic [ADDR_W-1:0] COLLISION_CLR_ADDR = {{(ADDR_W-2){1'b1}}, 2'b01};

    logic collision_hit;

    assign collision_hit = wr_a[0] & wr_a[1] & (addr_a[0] == addr_a[1]) &
                           (|(be_a[0] & be_a[1]));

    // Saturating count of overlapping same-word writes; NIOS clears it via DEPTH-3.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            collision_count <= '0;
        end else if (wr_a[0] && addr_a[0] == COLLISION_CLR_ADDR) begin
            collision_count <= '0;
        end else if (collision_hit && collision_count != 16'hFFFF) begin
            collision_count <= collision_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fluid_board_soc_dpram_mailbox.sv
// Directed self-checking bench for fluid_board_soc_dpram_mailbox.
// u_dut uses the default READ_LATENCY of 1; u_dut_rl2 uses READ_LATENCY 2.
module tb_fluid_board_soc_dpram_mailbox;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 14;
    localparam int BE_W   = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset_req = 1'b0;

    logic [ADDR_W-1:0] address, address2;
    logic [BE_W-1:0]   byteenable, byteenable2;
    logic              chipselect, chipselect2, read, read2, write, write2, clken, clken2;
    logic [DATA_W-1:0] writedata, writedata2, readdata, readdata2;
    logic              readdatavalid, readdatavalid2, irq, irq2;

    logic [ADDR_W-1:0] b_address;
    logic [BE_W-1:0]   b_byteenable;
    logic              b_chipselect, b_read, b_write, b_clken;
    logic [DATA_W-1:0] b_writedata, b_readdata, b_readdata2;
    logic              b_readdatavalid, b_readdatavalid2, b_irq, b_irq2;
    logic [ADDR_W-1:0] b_address2    = '0;
    logic [BE_W-1:0]   b_byteenable2 = '0;
    logic              b_zero        = 1'b0;
    logic              b_one         = 1'b1;
    logic [DATA_W-1:0] b_writedata2  = '0;

`ifdef FLUID_DPRAM_COLLISION_CNT_EN
    logic [15:0] collision_count, b_collision_count;
`endif

    int checks = 0;
    int errors = 0;

    // RL2 stall table: read enable, address, clken per cycle.
    int unsigned rd_en_t [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    int unsigned addr_t  [8] = '{0, 1, 1, 2, 0, 0, 0, 0};
    int unsigned ck_t    [8] = '{1, 0, 1, 1, 1, 1, 1, 1};
    logic [DATA_W-1:0] got_q [$];

    always #5 clk = ~clk;

    fluid_board_soc_dpram_mailbox u_dut (
        .clk(clk), .reset(reset), .reset_req(reset_req),
        .address(address), .byteenable(byteenable), .chipselect(chipselect),
        .read(read), .write(write), .writedata(writedata), .clken(clken),
        .readdata(readdata), .readdatavalid(readdatavalid),
        .address2(address2), .byteenable2(byteenable2), .chipselect2(chipselect2),
        .read2(read2), .write2(write2), .writedata2(writedata2), .clken2(clken2),
        .readdata2(readdata2), .readdatavalid2(readdatavalid2),
        .irq(irq), .irq2(irq2)
`ifdef FLUID_DPRAM_COLLISION_CNT_EN
        , .collision_count(collision_count)
`endif
    );

    fluid_board_soc_dpram_mailbox #(.READ_LATENCY(2)) u_dut_rl2 (
        .clk(clk), .reset(reset), .reset_req(b_zero),
        .address(b_address), .byteenable(b_byteenable), .chipselect(b_chipselect),
        .read(b_read), .write(b_write), .writedata(b_writedata), .clken(b_clken),
        .readdata(b_readdata), .readdatavalid(b_readdatavalid),
        .address2(b_address2), .byteenable2(b_byteenable2), .chipselect2(b_zero),
        .read2(b_zero), .write2(b_zero), .writedata2(b_writedata2), .clken2(b_one),
        .readdata2(b_readdata2), .readdatavalid2(b_readdatavalid2),
        .irq(b_irq), .irq2(b_irq2)
`ifdef FLUID_DPRAM_COLLISION_CNT_EN
        , .collision_count(b_collision_count)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        chipselect = 1'b0; read = 1'b0; write = 1'b0; clken = 1'b1;
        address = '0; byteenable = '0; writedata = '0;
        chipselect2 = 1'b0; read2 = 1'b0; write2 = 1'b0; clken2 = 1'b1;
        address2 = '0; byteenable2 = '0; writedata2 = '0;
    endtask

    task automatic b_idle();
        b_chipselect = 1'b0; b_read = 1'b0; b_write = 1'b0; b_clken = 1'b1;
        b_address = '0; b_byteenable = '0; b_writedata = '0;
    endtask

    task automatic p1_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
        chipselect = 1'b1; write = 1'b1; read = 1'b0; address = a; writedata = d; byteenable = be;
    endtask

    task automatic p2_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
        chipselect2 = 1'b1; write2 = 1'b1; read2 = 1'b0; address2 = a; writedata2 = d; byteenable2 = be;
    endtask

    task automatic p1_rd(input logic [ADDR_W-1:0] a);
        chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a; byteenable = '1;
    endtask

    task automatic p2_rd(input logic [ADDR_W-1:0] a);
        chipselect2 = 1'b1; read2 = 1'b1; write2 = 1'b0; address2 = a; byteenable2 = '1;
    endtask

    task automatic b_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        b_chipselect = 1'b1; b_write = 1'b1; b_read = 1'b0; b_address = a; b_writedata = d; b_byteenable = '1;
    endtask

    task automatic b_rd(input logic [ADDR_W-1:0] a);
        b_chipselect = 1'b1; b_read = 1'b1; b_write = 1'b0; b_address = a; b_byteenable = '1;
    endtask

    initial begin
        logic [DATA_W-1:0] seen;
        idle();
        b_idle();
        repeat (3) tick();

        // Reset values
        check_val("rst_readdata",   32'(readdata), 32'h0);
        check_val("rst_readdata2",  32'(readdata2), 32'h0);
        check_val("rst_rdv",        32'(readdatavalid), 32'h0);
        check_val("rst_rdv2",       32'(readdatavalid2), 32'h0);
        check_val("rst_irq",        32'(irq), 32'h0);
        check_val("rst_irq2",       32'(irq2), 32'h0);
        check_val("rst_b_readdata", 32'(b_readdata), 32'h0);
        check_val("rst_b_rdata2",   32'(b_readdata2), 32'h0);
        check_val("rst_b_rdv",      32'(b_readdatavalid), 32'h0);
        check_val("rst_b_rdv2",     32'(b_readdatavalid2), 32'h0);
        check_val("rst_b_irqs",     32'({b_irq, b_irq2}), 32'h0);
`ifdef FLUID_DPRAM_COLLISION_CNT_EN
        check_val("rst_coll_cnt",   32'(collision_count), 32'h0);
        check_val("rst_b_coll_cnt", 32'(b_collision_count), 32'h0);
`endif
        reset = 1'b0;
        tick();

        // Port-1 write, port-2 read back with latency 1
        p1_wr(14'h0010, 16'hA55A, 2'b11);
        tick(); idle();
        check_val("wr_no_rdv2", 32'(readdatavalid2), 32'h0);
        p2_rd(14'h0010);
        tick(); idle();
        check_val("xport_rdv2",  32'(readdatavalid2), 32'h1);
        check_val("xport_data2", 32'(readdata2), 32'hA55A);
        tick();
        check_val("rdv2_pulse",  32'(readdatavalid2), 32'h0);
        check_val("rdata2_hold", 32'(readdata2), 32'hA55A);

        // Same-address dual write: shared lane 0 from port 1, lane 1 from port 2
        p1_wr(14'h0020, 16'h1234, 2'b01);
        p2_wr(14'h0020, 16'hABCD, 2'b11);
        tick(); idle();
        p1_rd(14'h0020);
        tick(); idle();
        check_val("coll_rdv",  32'(readdatavalid), 32'h1);
        check_val("coll_data", 32'(readdata), 32'hAB34);
`ifdef FLUID_DPRAM_COLLISION_CNT_EN
        check_val("coll_cnt_1", 32'(collision_count), 32'h1);
`endif

        // Cross-port read-during-write returns old data
        p1_wr(14'h0020, 16'h5555, 2'b11);
        p2_rd(14'h0020);
        tick(); idle();
        check_val("rdw_old", 32'(readdata2), 32'hAB34);
        p1_rd(14'h0020);
        tick(); idle();
        check_val("rdw_new", 32'(readdata), 32'h5555);
`ifdef FLUID_DPRAM_COLLISION_CNT_EN
        p1_wr(14'h3FFD, 16'h0000, 2'b11);
        tick(); idle();
        check_val("coll_cnt_clr", 32'(collision_count), 32'h0);
`endif

        // Doorbell to ARM
        p1_wr(14'h3FFF, 16'hBEEF, 2'b11);
        tick(); idle();
        check_val("irq2_set",   32'(irq2), 32'h1);
        check_val("irq_quiet",  32'(irq), 32'h0);
        p1_wr(14'h3FFF, 16'hBEF0, 2'b11);
        p2_rd(14'h3FFF);
        tick(); idle();
        check_val("irq2_set_wins", 32'(irq2), 32'h1);
        check_val("db_old_data",   32'(readdata2), 32'hBEEF);
        tick();
        p2_rd(14'h3FFF);
        tick(); idle();
        check_val("irq2_clr",     32'(irq2), 32'h0);
        check_val("db_ram_word",  32'(readdata2), 32'hBEF0);

        // Doorbell to NIOS
        p2_wr(14'h3FFE, 16'h0C0C, 2'b11);
        tick(); idle();
        check_val("irq_set",      32'(irq), 32'h1);
        check_val("irq2_quiet",   32'(irq2), 32'h0);
        p1_rd(14'h3FFE);
        tick(); idle();
        check_val("irq_clr",      32'(irq), 32'h0);
        check_val("db2_ram_word", 32'(readdata), 32'h0C0C);

        // reset_req freezes both ports
        p2_wr(14'h0005, 16'h0BAD, 2'b11);
        tick(); idle();
        reset_req = 1'b1;
        p2_wr(14'h0005, 16'hFFFF, 2'b11);
        p1_rd(14'h0010);
        tick(); idle();
        reset_req = 1'b0;
        check_val("rreq_no_rdv", 32'(readdatavalid), 32'h0);
        p2_rd(14'h0005);
        tick(); idle();
        check_val("rreq_no_wr", 32'(readdata2), 32'h0BAD);

        // clken low ignores the access
        p1_rd(14'h0010);
        clken = 1'b0;
        tick(); idle();
        check_val("clken_no_rdv", 32'(readdatavalid), 32'h0);
        check_val("clken_hold",   32'(readdata), 32'h0C0C);

        // Upper-lane-only write
        p1_wr(14'h0010, 16'h7700, 2'b10);
        tick(); idle();
        p1_rd(14'h0010);
        tick(); idle();
        check_val("lane_hi", 32'(readdata), 32'h775A);

        // read+write together: write only
        p1_wr(14'h0030, 16'h1111, 2'b11);
        read = 1'b1;
        tick(); idle();
        check_val("rw_no_rdv", 32'(readdatavalid), 32'h0);
        p1_rd(14'h0030);
        tick(); idle();
        check_val("rw_written", 32'(readdata), 32'h1111);

        // READ_LATENCY=2: fill words 0..2
        for (int i = 0; i < 3; i++) begin
            b_wr(ADDR_W'(i), DATA_W'(16'h1000 + i));
            tick();
        end
        b_idle();
        b_rd(14'h0002);
        tick(); b_idle();
        check_val("rl2_lat_1", 32'(b_readdatavalid), 32'h0);
        tick();
        check_val("rl2_lat_2",  32'(b_readdatavalid), 32'h1);
        check_val("rl2_data",   32'(b_readdata), 32'h1002);
        tick();
        check_val("rl2_pulse",  32'(b_readdatavalid), 32'h0);

        // RL2 back-to-back reads with a stalled middle cycle
        for (int i = 0; i < 8; i++) begin
            b_chipselect = rd_en_t[i] != 0;
            b_read       = rd_en_t[i] != 0;
            b_address    = ADDR_W'(addr_t[i]);
            b_clken      = ck_t[i] != 0;
            tick();
            if (b_readdatavalid) got_q.push_back(b_readdata);
        end
        b_idle();
        check_val("rl2_stall_cnt", 32'(got_q.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            seen = (got_q.size() > k) ? got_q[k] : 16'hDEAD;
            check_val($sformatf("rl2_stall_d%0d", k), 32'(seen), 32'(16'h1000 + k));
        end

        // Async reset mid-read
        p1_wr(14'h3FFF, 16'h0001, 2'b11);
        tick(); idle();
        check_val("pre_rst_irq2", 32'(irq2), 32'h1);
        p1_rd(14'h0010);
        b_rd(14'h0001);
        tick(); idle(); b_idle();
        check_val("pre_rst_rdv", 32'(readdatavalid), 32'h1);
        #2 reset = 1'b1;
        #1;
        check_val("arst_rdv",      32'(readdatavalid), 32'h0);
        check_val("arst_b_rdv",    32'(b_readdatavalid), 32'h0);
        check_val("arst_irq2",     32'(irq2), 32'h0);
        check_val("arst_irq",      32'(irq), 32'h0);
        check_val("arst_readdata", 32'(readdata), 32'h0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val($sformatf("post_rst_b_rdv%0d", i), 32'(b_readdatavalid), 32'h0);
        end
        check_val("post_rst_rdv", 32'(readdatavalid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
